// File: rtl/mash_sdm_pkg.sv
// Shared constants and types for the parametrised MASH sigma-delta modulator.
// The dither LFSR constants are used only when MASH_SDM_DITHER_EN is defined.
package mash_sdm_pkg;

    localparam int ORDER_MAX = 4;

    // Fibonacci LFSR for x^17 + x^14 + 1: feedback taps are bits 16 and 13.
    localparam int              LFSR_W    = 17;
    localparam logic [16:0]     LFSR_SEED = 17'h0_0001;
    localparam logic [16:0]     LFSR_TAPS = 17'h1_2000;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } sdm_state_t;

    function automatic int out_width(input int int_w);
        return int_w + 2;
    endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One first-order MASH stage: a FRAC_W accumulator that exposes its overflow
// carry and wrapped sum (the quantisation error fed to the next stage).
module mash_acc_stage
    import mash_sdm_pkg::*;
#(
    parameter int                FRAC_W  = 16,
    parameter logic [FRAC_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [FRAC_W-1:0] x,
    input  logic              cin,
    output logic              carry,
    output logic [FRAC_W-1:0] err
);

    logic [FRAC_W-1:0] acc_reg;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc_reg} + {1'b0, x} + {{FRAC_W{1'b0}}, cin};
    assign carry = sum[FRAC_W];
    assign err   = sum[FRAC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= RST_VAL;
        end else if (clr) begin
            acc_reg <= RST_VAL;
        end else if (en) begin
            acc_reg <= err;
        end
    end

endmodule

// File: rtl/mash_sdm_param.sv
// Parametrised MASH sigma-delta modulator: ORDER cascaded accumulators, noise
// cancellation network, warm-up FSM and shadowed word. Option: MASH_SDM_DITHER_EN.
module mash_sdm_param
    import mash_sdm_pkg::*;
#(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 4,
    parameter int ORDER  = 3,
    parameter int SEED   = 1,
    localparam int OUT_W = out_width(INT_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [INT_W-1:0]        in_i,
    input  logic [FRAC_W-1:0]       in_f,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid
);

    localparam int               CNT_W     = $clog2(ORDER_MAX);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(ORDER - 1);

    if (ORDER < 1 || ORDER > ORDER_MAX) begin : g_order_check
        $error("mash_sdm_param: ORDER must lie in 1..%0d", ORDER_MAX);
    end

    logic [INT_W-1:0]        int_q;
    logic [FRAC_W-1:0]       frac_q;
    logic [ORDER-1:0]        carry;
    logic [FRAC_W-1:0]       err [ORDER];
    logic signed [OUT_W-1:0] y   [ORDER];
    logic                    dither_bit;
    logic                    unused_err;
    sdm_state_t              state_reg, state_next;
    logic [CNT_W-1:0]        warm_cnt_reg, warm_cnt_next;

    // clr blocks the handshake so a word offered during clear stays with the source.
    assign cfg_ready  = en && !clr;
    assign unused_err = ^err[ORDER-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q  <= '0;
            frac_q <= '0;
        end else if (cfg_valid && cfg_ready) begin
            int_q  <= in_i;
            frac_q <= in_f;
        end
    end

`ifdef MASH_SDM_DITHER_EN
    logic [LFSR_W-1:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (clr) begin
            lfsr_reg <= LFSR_SEED;
        end else if (en) begin
            lfsr_reg <= {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign dither_bit = lfsr_reg[LFSR_W-1];
`else
    assign dither_bit = 1'b0;
`endif

    // Accumulator cascade: all stages settle in the same cycle.
    for (genvar gi = 0; gi < ORDER; gi++) begin : g_stage
        logic [FRAC_W-1:0] x;
        logic              cin;

        if (gi == 0) begin : g_head
            assign x = frac_q;
        end else begin : g_chain
            assign x = err[gi-1];
        end

        if (gi == ORDER - 1) begin : g_tail
            assign cin = dither_bit;
        end else begin : g_inner
            assign cin = 1'b0;
        end

        mash_acc_stage #(
            .FRAC_W  (FRAC_W),
            .RST_VAL ((gi == 0) ? FRAC_W'(SEED) : {FRAC_W{1'b0}})
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .clr   (clr),
            .x     (x),
            .cin   (cin),
            .carry (carry[gi]),
            .err   (err[gi])
        );
    end

    // Noise cancellation: y_k = c_k + y_(k+1) - y_(k+1) delayed one enabled cycle.
    for (genvar gi = 0; gi < ORDER; gi++) begin : g_nc
        logic signed [OUT_W-1:0] c_ext;

        assign c_ext = {{(OUT_W-1){1'b0}}, carry[gi]};

        if (gi == ORDER - 1) begin : g_last
            assign y[gi] = c_ext;
        end else begin : g_diff
            logic signed [OUT_W-1:0] y_d_reg;

            assign y[gi] = c_ext + y[gi+1] - y_d_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_d_reg <= '0;
                end else if (clr) begin
                    y_d_reg <= '0;
                end else if (en) begin
                    y_d_reg <= y[gi+1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (clr) begin
            out <= '0;
        end else if (en) begin
            out <= $signed({2'b00, int_q}) + y[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WARM;
            warm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        out_valid     = (state_reg == RUN);
        if (clr) begin
            state_next    = WARM;
            warm_cnt_next = '0;
        end else if (en) begin
            case (state_reg)
                WARM: begin
                    if (warm_cnt_reg == WARM_LAST) begin
                        state_next = RUN;
                    end else begin
                        warm_cnt_next = warm_cnt_reg + 1'b1;
                    end
                end
                RUN:     state_next = RUN;
                default: state_next = WARM;
            endcase
        end
    end

endmodule

// File: tb/tb_mash_sdm_param.sv
// Directed self-checking bench: three modulator instances (ORDER 1, 3, 4) share
// clock, reset and stimulus; each scenario checks the instance it targets.
module tb_mash_sdm_param;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b1;
    logic              clr = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [3:0]        in_i = '0;
    logic [15:0]       in_f = '0;
    logic              cfg_ready1, cfg_ready3, cfg_ready4;
    logic              v1, v3, v4;
    logic signed [5:0] out1, out3, out4;

    int n_checks = 0;
    int n_errors = 0;

    int   o1 [1:8];
    int   o3 [1:8];
    logic w1 [1:8];
    logic w3 [1:8];
    logic w4 [1:8];

    int sum1, sum3, sum4, min1, max1, min3, max3, min4, max4, xcnt4, inval3, rec;

    always #5 clk = ~clk;

    mash_sdm_param #(.FRAC_W(16), .INT_W(4), .ORDER(1), .SEED(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready1), .in_i(in_i), .in_f(in_f), .out(out1), .out_valid(v1)
    );

    mash_sdm_param #(.FRAC_W(16), .INT_W(4), .ORDER(3), .SEED(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready3), .in_i(in_i), .in_f(in_f), .out(out3), .out_valid(v3)
    );

    mash_sdm_param #(.FRAC_W(16), .INT_W(4), .ORDER(4), .SEED(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready4), .in_i(in_i), .in_f(in_f), .out(out4), .out_valid(v4)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("pass %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record the first eight enabled cycles after a clear.
    task automatic warm();
        for (int k = 1; k <= 8; k++) begin
            tick();
            o1[k] = int'(out1);
            o3[k] = int'(out3);
            w1[k] = v1;
            w3[k] = v3;
            w4[k] = v4;
        end
    endtask

    task automatic restart(input int ii, input int ff);
        in_i      = 4'(ii);
        in_f      = 16'(ff);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        clr       = 1'b1;
        tick();
        clr       = 1'b0;
        check("clr_out3", int'(out3), 0);
        check("clr_valid3", int'(v3), 0);
        warm();
    endtask

    task automatic run_window(input int n);
        sum1 = 0; sum3 = 0; sum4 = 0; xcnt4 = 0; inval3 = 0;
        min1 = 999; max1 = -999; min3 = 999; max3 = -999; min4 = 999; max4 = -999;
        for (int k = 0; k < n; k++) begin
            tick();
            sum1 += int'(out1);
            sum3 += int'(out3);
            sum4 += int'(out4);
            if (int'(out1) < min1) min1 = int'(out1);
            if (int'(out1) > max1) max1 = int'(out1);
            if (int'(out3) < min3) min3 = int'(out3);
            if (int'(out3) > max3) max3 = int'(out3);
            if (int'(out4) < min4) min4 = int'(out4);
            if (int'(out4) > max4) max4 = int'(out4);
            if ($isunknown(out4)) xcnt4++;
            if (!v3) inval3++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out3", int'(out3), 0);
        check("rst_valid3", int'(v3), 0);
        check("rst_ready1", int'(cfg_ready1), 1);
        check("rst_ready3", int'(cfg_ready3), 1);
        check("rst_ready4", int'(cfg_ready4), 1);
        rst_n = 1'b1;

        // ORDER=1, 4 + 1/2: alternates 4,5; warm-up lengths of all orders.
        restart(4, 'h8000);
        check("o1_valid_t1", int'(w1[1]), 1);
        check("o1_t1", o1[1], 4);
        check("o1_t2", o1[2], 5);
        check("o1_t3", o1[3], 4);
        check("o3_valid_t2", int'(w3[2]), 0);
        check("o3_valid_t3", int'(w3[3]), 1);
        check("o4_valid_t3", int'(w4[3]), 0);
        check("o4_valid_t4", int'(w4[4]), 1);
        run_window(1024);
        check("o1_sum1024", sum1, 4608);

        // ORDER=3, 6 + 1/4: first valid samples 5,8,4; exact mean; bounded noise.
        restart(6, 'h4000);
        check("o3_t3", o3[3], 5);
        check("o3_t4", o3[4], 8);
        check("o3_t5", o3[5], 4);
        run_window(1024);
        check("o3_sum1024", sum3, 6400);
        check("o3_min_ge3", int'(min3 >= 3), 1);
        check("o3_max_le10", int'(max3 <= 10), 1);

        // int part 0: output goes negative without saturation.
        restart(0, 'h4000);
        check("neg_t3", o3[3], -1);
        check("neg_t4", o3[4], 2);
        check("neg_t5", o3[5], -2);

        // ORDER=4 at full-scale fraction.
        restart(0, 'hFFFF);
        run_window(1024);
        check("o4_sum_ge1017", int'(sum4 >= 1017), 1);
        check("o4_sum_le1031", int'(sum4 <= 1031), 1);
        check("o4_min_ge_m7", int'(min4 >= -7), 1);
        check("o4_max_le8", int'(max4 <= 8), 1);
        check("o4_no_x", xcnt4, 0);

        // Mid-run word load 1/16 -> 3/4 without re-warm.
        restart(6, 'h1000);
        in_f      = 16'hC000;
        cfg_valid = 1'b1;
        check("load_ready", int'(cfg_ready3), 1);
        tick();
        cfg_valid = 1'b0;
        check("load_valid", int'(v3), 1);
        run_window(8);
        check("load_no_drop", inval3, 0);
        run_window(1024);
        check("load_sum1024", sum3, 6912);

        // en low freezes output and blocks the handshake.
        rec = int'(out3);
        en  = 1'b0;
        #1;
        check("en0_ready", int'(cfg_ready3), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("freeze_out", int'(out3), rec);
        end
        check("freeze_valid", int'(v3), 1);
        en = 1'b1;

        // clr in RUN beats a simultaneous word offer.
        clr       = 1'b1;
        cfg_valid = 1'b1;
        in_f      = 16'h0000;
        #1;
        check("clr_ready", int'(cfg_ready3), 0);
        tick();
        clr       = 1'b0;
        cfg_valid = 1'b0;
        check("clrrun_out", int'(out3), 0);
        check("clrrun_valid", int'(v3), 0);
        warm();
        check("clrrun_valid_t2", int'(w3[2]), 0);
        check("clrrun_valid_t3", int'(w3[3]), 1);
        run_window(1024);
        check("clr_kept_word", sum3, 6912);

        // Asynchronous reset mid-stream, then shadow word must read back as zero.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out3", int'(out3), 0);
        check("arst_valid3", int'(v3), 0);
        check("arst_out1", int'(out1), 0);
        check("arst_valid4", int'(v4), 0);
        check("arst_ready3", int'(cfg_ready3), 1);
        tick();
        tick();
        rst_n = 1'b1;
        warm();
        check("post_rst_valid_t3", int'(w3[3]), 1);
        check("post_rst_out_t8", o3[8], 0);

`ifdef MASH_SDM_DITHER_EN
        // Zero fraction with dither: one LFSR period adds exactly one carry.
        restart(5, 0);
        run_window(131072);
        check("dither_varies", int'(max1 > min1), 1);
        check("dither_sum_lo", int'(sum1 >= 655357), 1);
        check("dither_sum_hi", int'(sum1 <= 655365), 1);
`else
        // Zero fraction without dither: constant int part.
        restart(9, 0);
        run_window(64);
        check("frac0_min3", min3, 9);
        check("frac0_max3", max3, 9);
        check("frac0_min1", min1, 9);
        check("frac0_max1", max1, 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
